// File: rtl/rc4_host_pkg.sv
// rc4_host_pkg: state encoding, default sizes and load-port selectors for the RC4 stream host.
package rc4_host_pkg;
    typedef enum logic [2:0] {IDLE, KEY, PLAIN, CIPHER, DONE} state_t;
    localparam int DEF_DEPTH = 2048;
    localparam int DEF_AW = 11;
    localparam int DEF_KEY_MAX = 32;
    localparam logic HOST_SEL_KEY = 1'b0;
    localparam logic HOST_SEL_PLAIN = 1'b1;
endpackage

// File: rtl/rc4_byte_ram.sv
// rc4_byte_ram: byte RAM with one write port and two registered read ports.
module rc4_byte_ram #(
    parameter int DEPTH = 2048,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re_a,
    input  logic [AW-1:0] raddr_a,
    output logic [7:0]    rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [7:0]    rdata_b
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // Only the read registers are reset so the stream outputs come up at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end
endmodule

// File: rtl/rc4_stream_host.sv
// rc4_stream_host: far end of the RC4 core byte-stream protocol; streams key and plaintext,
// captures and replays ciphertext, and scores the decrypted bytes.
module rc4_stream_host
    import rc4_host_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW = DEF_AW,
    parameter int KEY_MAX = DEF_KEY_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [5:0]    key_len_i,
    input  logic [AW:0]   plain_len_i,
    input  logic          host_we,
    input  logic          host_sel,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    input  logic [AW-1:0] host_raddr,
    output logic [7:0]    host_rdata,
    output logic          key_valid,
    output logic [7:0]    key_in,
    input  logic          plain_read,
    output logic          plain_in_valid,
    output logic [7:0]    plain_in,
    input  logic          cipher_write,
    input  logic [7:0]    cipher_out,
    input  logic          cipher_read,
    output logic          cipher_in_valid,
    output logic [7:0]    cipher_in,
    input  logic          plain_write,
    input  logic [7:0]    plain_out,
    input  logic          done,
    output logic          busy,
    output logic          finished,
    output logic [AW:0]   cipher_cnt,
    output logic [AW:0]   err_count,
    output logic          len_err,
    output logic          ovf
);
    localparam int KAW = $clog2(KEY_MAX);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t state, state_nxt;
    logic [5:0] key_len, k;
    logic [AW:0] plain_len, p, c, r, r_nxt;
    logic [7:0] key_rd, plain_chk;
    logic idle_like, go, key_more, plain_req, end_mark, cipher_req, cap, full, chk;
    assign idle_like = state == IDLE || state == DONE;
    assign go = idle_like && start && key_len_i != 6'd0;
    assign key_more = state == KEY && k < key_len;
    assign plain_req = state == PLAIN && plain_read && !plain_write;
    assign end_mark = plain_req && p >= plain_len;
    assign cipher_req = state == CIPHER && cipher_read && !cipher_write;
    assign cap = (state == PLAIN || state == CIPHER) && cipher_write;
    assign full = cipher_cnt == FULL;
    assign chk = state == CIPHER && plain_write;
    // The check port is addressed one step ahead so plain[r] is ready when the next byte lands.
    assign r_nxt = go ? '0 : (chk && r != '1) ? r + 1'b1 : r;
    assign key_in = key_valid ? key_rd : 8'd0;
    assign busy = state == KEY || state == PLAIN || state == CIPHER;
    assign finished = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (go) state_nxt = KEY;
        else if (state == KEY && !key_more) state_nxt = PLAIN;
        else if (end_mark) state_nxt = CIPHER;
        else if (state == CIPHER && done) state_nxt = DONE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_len <= '0;
            plain_len <= '0;
            k <= '0;
            p <= '0;
            c <= '0;
            r <= '0;
            key_valid <= 1'b0;
            plain_in_valid <= 1'b0;
            cipher_in_valid <= 1'b0;
            cipher_cnt <= '0;
            err_count <= '0;
            len_err <= 1'b0;
            ovf <= 1'b0;
        end else begin
            r <= r_nxt;
            key_valid <= go || key_more;
            if (go) begin
                key_len <= key_len_i;
                plain_len <= plain_len_i;
                k <= 6'd1;
                p <= '0;
                c <= '0;
                cipher_cnt <= '0;
                err_count <= '0;
                len_err <= 1'b0;
                ovf <= 1'b0;
            end else begin
                if (key_more) k <= k + 1'b1;
                if (plain_req) begin
                    plain_in_valid <= p < plain_len;
                    p <= p + 1'b1;
                end
                if (cipher_req) begin
                    cipher_in_valid <= c < cipher_cnt;
                    if (c != '1) c <= c + 1'b1;
                end
                if (cap && full) ovf <= 1'b1;
                if (cap && !full) cipher_cnt <= cipher_cnt + 1'b1;
                if (chk && (r >= plain_len || plain_out != plain_chk) && err_count != '1)
                    err_count <= err_count + 1'b1;
                if (state == CIPHER && done) len_err <= r != plain_len;
            end
        end
    end
    rc4_byte_ram #(.DEPTH(KEY_MAX), .AW(KAW)) u_key (
        .clk(clk), .rst(rst),
        .we(host_we && host_sel == HOST_SEL_KEY && idle_like),
        .waddr(KAW'(host_addr)), .wdata(host_wdata),
        .re_a(1'b1), .raddr_a(go ? '0 : k[KAW-1:0]), .rdata_a(key_rd),
        .raddr_b('0), .rdata_b()
    );
    rc4_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_plain (
        .clk(clk), .rst(rst),
        .we(host_we && host_sel == HOST_SEL_PLAIN && idle_like),
        .waddr(host_addr), .wdata(host_wdata),
        .re_a(plain_req), .raddr_a(p[AW-1:0]), .rdata_a(plain_in),
        .raddr_b(r_nxt[AW-1:0]), .rdata_b(plain_chk)
    );
    rc4_byte_ram #(.DEPTH(DEPTH), .AW(AW)) u_cipher (
        .clk(clk), .rst(rst),
        .we(cap && !full), .waddr(cipher_cnt[AW-1:0]), .wdata(cipher_out),
        .re_a(cipher_req), .raddr_a(c[AW-1:0]), .rdata_a(cipher_in),
        .raddr_b(host_raddr), .rdata_b(host_rdata)
    );
endmodule

// File: tb/tb_rc4_stream_host.sv
// tb_rc4_stream_host: drives the host with a behavioural RC4 core and checks against a byte-level model.
module tb_rc4_stream_host;
    localparam int D = 16;
    localparam int AW = 4;
    logic clk = 0, rst = 1, start = 0;
    logic [5:0] key_len_i = 0;
    logic [AW:0] plain_len_i = 0;
    logic host_we = 0, host_sel = 0;
    logic [AW-1:0] host_addr = 0, host_raddr = 0;
    logic [7:0] host_wdata = 0, host_rdata, key_in, plain_in, cipher_in;
    logic key_valid, plain_in_valid, cipher_in_valid, busy, finished, len_err, ovf;
    logic plain_read = 0, cipher_write = 0, cipher_read = 0, plain_write = 0, done = 0;
    logic [7:0] cipher_out = 0, plain_out = 0;
    logic [AW:0] cipher_cnt, err_count;
    logic [48:0] outs;
    int checks = 0, errors = 0;
    logic [7:0] key_m [32];
    logic [7:0] plain_m [D];
    logic [7:0] ks [64];
    logic [7:0] exp_q [$];
    assign outs = {key_valid, key_in, plain_in_valid, plain_in, cipher_in_valid, cipher_in,
                   busy, finished, cipher_cnt, err_count, len_err, ovf, host_rdata};
    rc4_stream_host #(.DEPTH(D), .AW(AW), .KEY_MAX(32)) dut (
        .clk(clk), .rst(rst), .start(start), .key_len_i(key_len_i), .plain_len_i(plain_len_i),
        .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata), .key_valid(key_valid), .key_in(key_in),
        .plain_read(plain_read), .plain_in_valid(plain_in_valid), .plain_in(plain_in),
        .cipher_write(cipher_write), .cipher_out(cipher_out), .cipher_read(cipher_read),
        .cipher_in_valid(cipher_in_valid), .cipher_in(cipher_in), .plain_write(plain_write),
        .plain_out(plain_out), .done(done), .busy(busy), .finished(finished),
        .cipher_cnt(cipher_cnt), .err_count(err_count), .len_err(len_err), .ovf(ovf)
    );
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic make_ks(input int klen, input int n);
        int s [256];
        int j, t, a, b;
        for (int i = 0; i < 256; i++) s[i] = i;
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + s[i] + int'(key_m[i % klen])) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        a = 0; b = 0;
        for (int i = 0; i < n; i++) begin
            a = (a + 1) % 256;
            b = (b + s[a]) % 256;
            t = s[a]; s[a] = s[b]; s[b] = t;
            ks[i] = 8'(s[(s[a] + s[b]) % 256]);
        end
    endtask
    task automatic load(input logic sel, input int addr, input logic [7:0] d);
        @(negedge clk);
        host_we = 1; host_sel = sel; host_addr = AW'(addr); host_wdata = d;
        @(negedge clk);
        host_we = 0;
        if (sel) plain_m[addr] = d;
        else key_m[addr] = d;
    endtask
    task automatic load_str(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) load(sel, i, s[i]);
    endtask
    task automatic readback(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); host_raddr = AW'(i);
            @(negedge clk); check(tag, host_rdata, exp_q[i]);
        end
    endtask
    task automatic expect_vec(input string tag, input logic [71:0] v, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(v[71-8*i -: 8]);
        readback(tag, n);
    endtask
    // One full run as the RC4 core would perform it, with random gaps and strobe collisions.
    task automatic run(input int klen, input int plen, input bit corrupt, input bit extra_w,
                       input int extra_c, input bit poke);
        logic [7:0] pend [$];
        logic [7:0] sent [$];
        logic [7:0] dq [$];
        logic [7:0] wr [$];
        int n, got, cyc, exp_cnt, exp_err;
        bit fin, rd, cw, pw, blk;
        make_ks(klen, plen + extra_c);
        @(negedge clk); start = 1; key_len_i = 6'(klen); plain_len_i = (AW+1)'(plen);
        @(negedge clk); start = 0;
        n = 0;
        while (key_valid && n < 40) begin
            check("key_byte", key_in, key_m[n % 32]);
            n++;
            @(negedge clk);
        end
        check("key_len", n, klen);
        check("key_idle", key_in, 0);
        check("busy_run", busy, 1);
        got = 0; fin = 0; cyc = 0;
        while (!fin && cyc < 500) begin
            rd = $urandom_range(0, 3) != 0;
            blk = rd && $urandom_range(0, 7) == 0;
            cw = pend.size() > 0 && $urandom_range(0, 1) == 1;
            plain_read = rd; plain_write = blk; plain_out = 8'($urandom);
            cipher_write = cw;
            if (cw) begin
                cipher_out = pend.pop_front();
                sent.push_back(cipher_out);
            end
            host_we = poke && $urandom_range(0, 2) == 0;
            host_sel = 1'($urandom); host_addr = AW'($urandom);
            host_wdata = host_sel ? ~plain_m[host_addr] : ~key_m[host_addr];
            @(negedge clk);
            {plain_read, plain_write, cipher_write, host_we} = '0;
            if (rd && !blk && got < plen) begin
                check("plain_valid", plain_in_valid, 1);
                check("plain_byte", plain_in, plain_m[got]);
                pend.push_back(plain_m[got] ^ ks[got]);
                got++;
            end else if (rd && !blk) begin
                check("plain_end", plain_in_valid, 0);
                fin = 1;
            end
            cyc++;
        end
        check("plain_done", fin, 1);
        repeat (extra_c) pend.push_back(8'($urandom));
        while (pend.size() > 0) begin
            cipher_write = 1; cipher_out = pend.pop_front(); sent.push_back(cipher_out);
            cipher_read = $urandom_range(0, 3) == 0;
            @(negedge clk);
            cipher_write = 0; cipher_read = 0;
        end
        exp_cnt = sent.size() < D ? sent.size() : D;
        got = 0; fin = 0; cyc = 0;
        while (!(fin && dq.size() == 0) && cyc < 500) begin
            rd = !fin && $urandom_range(0, 3) != 0;
            pw = dq.size() > 0 && $urandom_range(0, 1) == 1;
            cipher_read = rd; plain_write = pw;
            if (pw) begin
                plain_out = dq.pop_front();
                wr.push_back(plain_out);
            end
            @(negedge clk);
            cipher_read = 0; plain_write = 0;
            if (rd && got < exp_cnt) begin
                check("cipher_valid", cipher_in_valid, 1);
                check("cipher_byte", cipher_in, sent[got]);
                dq.push_back(sent[got] ^ ks[got] ^ ((corrupt && got == 2) ? 8'h01 : 8'h00));
                got++;
            end else if (rd) begin
                check("cipher_end", cipher_in_valid, 0);
                fin = 1;
            end
            cyc++;
        end
        check("cipher_done", fin, 1);
        if (extra_w) begin
            plain_write = 1; plain_out = 8'($urandom); wr.push_back(plain_out);
            @(negedge clk);
            plain_write = 0;
        end
        done = 1;
        @(negedge clk);
        done = 0;
        exp_err = 0;
        foreach (wr[i]) begin
            if (i >= plen) exp_err++;
            else if (wr[i] != plain_m[i]) exp_err++;
        end
        check("finished", finished, 1);
        check("busy_done", busy, 0);
        check("cipher_cnt", cipher_cnt, exp_cnt);
        check("ovf", ovf, sent.size() > D);
        check("err_count", err_count, exp_err);
        check("len_err", len_err, wr.size() != plen);
        exp_q.delete();
        for (int i = 0; i < exp_cnt; i++) exp_q.push_back(sent[i]);
        readback("cipher_mem", exp_cnt);
    endtask
    task automatic reset_mid();
        int n;
        @(negedge clk); start = 1; key_len_i = 3; plain_len_i = 9;
        @(negedge clk); start = 0;
        n = 0;
        while (key_valid && n < 40) begin
            n++;
            @(negedge clk);
        end
        repeat (2) begin
            plain_read = 1;
            @(negedge clk);
            plain_read = 0;
        end
        cipher_write = 1; cipher_out = 8'h5A;
        @(negedge clk);
        cipher_write = 0;
        check("mid_busy", busy, 1);
        rst = 1;
        #1 check("mid_reset_outs", outs, 0);
        @(negedge clk);
        check("mid_reset_hold", outs, 0);
        rst = 0;
    endtask
    initial begin
        int kl, pl;
        repeat (3) @(negedge clk);
        check("reset_outs", outs, 0);
        rst = 0;
        load_str(0, "Key");
        load_str(1, "Plaintext");
        run(3, 9, 0, 0, 0, 0);
        expect_vec("vec1", 72'hBBF316E8D940AF0AD3, 9);
        @(negedge clk); start = 1; key_len_i = 0;
        @(negedge clk); start = 0;
        check("zero_key_busy", busy, 0);
        check("zero_key_fin", finished, 1);
        load_str(0, "Wiki");
        load_str(1, "pedia");
        run(4, 5, 0, 0, 0, 0);
        expect_vec("vec2", {40'h1021BF0420, 32'h0}, 5);
        load_str(0, "Key");
        run(3, 0, 0, 0, 0, 0);
        load_str(1, "Plaintext");
        run(3, 9, 1, 1, 0, 0);
        check("corrupt_err", err_count, 2);
        check("corrupt_len", len_err, 1);
        for (int i = 0; i < D; i++) load(1, i, 8'($urandom));
        run(3, 16, 0, 0, 4, 1);
        check("ovf_cnt", cipher_cnt, 16);
        check("ovf_flag", ovf, 1);
        run(3, 16, 0, 0, 0, 0);
        load_str(1, "Plaintext");
        reset_mid();
        run(3, 9, 0, 0, 0, 0);
        expect_vec("vec1_rerun", 72'hBBF316E8D940AF0AD3, 9);
        for (int t = 0; t < 8; t++) begin
            kl = $urandom_range(1, 16);
            pl = $urandom_range(0, 16);
            for (int i = 0; i < kl; i++) load(0, i, 8'($urandom));
            for (int i = 0; i < pl; i++) load(1, i, 8'($urandom));
            run(kl, pl, 1'($urandom), 1'($urandom), $urandom_range(0, 5), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
